// File: rtl/store_rmw_unit_if.sv
// Datapath-to-store-unit and store-unit-to-dmem signal bundle.
// The slave modport is the store unit; the master side is the datapath plus dmem.
interface store_rmw_unit_if #(
    parameter int MEM_AW = 6,
    parameter int ERRW   = 8
);
    logic              st_valid;
    logic              st_half;
    logic              st_byte;
    logic [31:0]       st_addr;
    logic [31:0]       st_data;
    logic              stall;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_re;
    logic [31:0]       mem_rdata;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic              align_err;
    logic [ERRW-1:0]   err_count;

    modport slave (
        input  st_valid, st_half, st_byte, st_addr, st_data, mem_rdata,
        output stall, mem_addr, mem_re, mem_we, mem_wdata, align_err, err_count
    );

    modport master (
        output st_valid, st_half, st_byte, st_addr, st_data, mem_rdata,
        input  stall, mem_addr, mem_re, mem_we, mem_wdata, align_err, err_count
    );
endinterface

// File: rtl/store_rmw_unit.sv
// Executes sw/sh/sb into word-wide dmem; sub-word stores read, merge one lane and write back.
// Misaligned stores are dropped with a one-cycle align_err pulse and a saturating counter.
module store_rmw_unit #(
    parameter int MEM_AW = 6,
    parameter int ERRW   = 8
) (
    input  logic clk,
    input  logic reset,
    store_rmw_unit_if.slave bus
);

    typedef enum logic [1:0] {IDLE, READ, MERGE, WRITE} state_t;
    typedef enum logic [1:0] {SZ_WORD, SZ_HALF, SZ_BYTE} size_t;

    state_t            state, state_nx;
    size_t             req_size, size_q;
    logic [1:0]        lane_q;
    logic [15:0]       sdata_q;
    logic [31:0]       wbuf;
    logic [31:0]       merged;
    logic [MEM_AW-1:0] mem_addr_q;
    logic [ERRW-1:0]   err_q;
    logic              misaligned;
    logic              accept;
    logic              stall_c, re_c, we_c, err_c;
    logic              unused_addr;

    assign unused_addr = ^bus.st_addr[31:MEM_AW+2];

    always_comb begin
        if (bus.st_byte)      req_size = SZ_BYTE;
        else if (bus.st_half) req_size = SZ_HALF;
        else                  req_size = SZ_WORD;
    end

    assign misaligned = ((req_size == SZ_HALF) && bus.st_addr[0]) ||
                        ((req_size == SZ_WORD) && (bus.st_addr[1:0] != 2'b00));
    assign accept     = (state == IDLE) && bus.st_valid && !misaligned;

    // NOTE: every output of this block is given a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_nx = state;
        stall_c  = 1'b0;
        re_c     = 1'b0;
        we_c     = 1'b0;
        err_c    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.st_valid) begin
                    if (misaligned) begin
                        err_c = 1'b1;
                    end else begin
                        stall_c  = 1'b1;
                        state_nx = (req_size == SZ_WORD) ? WRITE : READ;
                    end
                end
            end
            READ: begin
                re_c     = 1'b1;
                stall_c  = 1'b1;
                state_nx = MERGE;
            end
            MERGE: begin
                stall_c  = 1'b1;
                state_nx = WRITE;
            end
            WRITE: begin
                we_c     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Lane replacement applied to the word fetched during READ.
    always_comb begin
        merged = bus.mem_rdata;
        case (size_q)
            SZ_BYTE: merged[{lane_q, 3'b000} +: 8]     = sdata_q[7:0];
            SZ_HALF: merged[{lane_q[1], 4'b0000} +: 16] = sdata_q;
            default: ;
        endcase
    end

    // NOTE: all state, including the write buffer, is cleared by reset so a killed store leaves no residue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            size_q     <= SZ_WORD;
            lane_q     <= 2'b00;
            sdata_q    <= '0;
            wbuf       <= '0;
            mem_addr_q <= '0;
            err_q      <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                size_q     <= req_size;
                lane_q     <= bus.st_addr[1:0];
                sdata_q    <= bus.st_data[15:0];
                mem_addr_q <= bus.st_addr[MEM_AW+1:2];
                if (req_size == SZ_WORD) wbuf <= bus.st_data;
            end
            if (state == MERGE) wbuf <= merged;
            if (err_c && (err_q != '1)) err_q <= err_q + 1'b1;
        end
    end

    // Combinational strobes are forced low while reset is held, even with a request pending.
    assign bus.stall     = stall_c & ~reset;
    assign bus.align_err = err_c & ~reset;
    assign bus.mem_re    = re_c;
    assign bus.mem_we    = we_c;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = wbuf;
    assign bus.err_count = err_q;

endmodule

// File: tb/tb_store_rmw_unit.sv
// Randomized bench for store_rmw_unit against a byte-mask memory model.
// Includes a word-wide dmem with a preload port and a sticky re/we exclusivity monitor.
module tb_store_rmw_unit;

    localparam int MEM_AW = 6;
    localparam int ERRW   = 8;
    localparam int DEPTH  = 1 << MEM_AW;

    logic clk = 1'b0;
    logic reset;

    store_rmw_unit_if #(.MEM_AW(MEM_AW), .ERRW(ERRW)) bus ();

    store_rmw_unit #(.MEM_AW(MEM_AW), .ERRW(ERRW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // dmem: registered read data, preload port for the bench
    logic [31:0]       dmem [DEPTH];
    logic              pl_en = 1'b0;
    logic [MEM_AW-1:0] pl_addr = '0;
    logic [31:0]       pl_data = '0;

    always @(posedge clk) begin
        if (bus.mem_re) bus.mem_rdata <= dmem[bus.mem_addr];
        if (bus.mem_we) dmem[bus.mem_addr] <= bus.mem_wdata;
        if (pl_en)      dmem[pl_addr] <= pl_data;
    end

    // Sticky monitor: checked once at the end so a violation anywhere is seen.
    int both_strobes = 0;
    int we_in_reset  = 0;
    always @(negedge clk) begin
        if (bus.mem_re && bus.mem_we) both_strobes++;
        if (reset && bus.mem_we)      we_in_reset++;
    end

    logic [31:0] ref_mem [DEPTH];
    int          ref_err = 0;

    task automatic preload(input int wa, input logic [31:0] v);
        pl_en = 1'b1; pl_addr = MEM_AW'(wa); pl_data = v;
        @(posedge clk); #1;
        pl_en = 1'b0;
        ref_mem[wa] = v;
    endtask

    // sz: 0 word, 1 half, 2 byte, 3 byte+half (byte wins). Starts and ends at posedge+1.
    task automatic do_store(input int sz, input logic [31:0] a, input logic [31:0] d);
        int          nbytes, sh, wa, cyc, n_stall, n_re, exp_cyc;
        bit          bad, done;
        logic [31:0] mask, exp_w;
        nbytes = (sz >= 2) ? 1 : (sz == 1) ? 2 : 4;
        bad    = (nbytes == 2 && a[0]) || (nbytes == 4 && a[1:0] != 2'b00);
        sh     = 8 * int'(a[1:0]);
        wa     = int'(a[MEM_AW+1:2]);
        mask   = (nbytes == 4) ? 32'hFFFF_FFFF : (nbytes == 2) ? (32'h0000_FFFF << sh) : (32'h0000_00FF << sh);
        exp_w  = (ref_mem[wa] & ~mask) | ((d << sh) & mask);

        bus.st_valid = 1'b1;
        bus.st_byte  = (sz >= 2);
        bus.st_half  = (sz == 1 || sz == 3);
        bus.st_addr  = a;
        bus.st_data  = d;

        if (bad) begin
            @(negedge clk);
            check("mis_align_err", bus.align_err, 1);
            check("mis_stall", bus.stall, 0);
            check("mis_strobes", {bus.mem_re, bus.mem_we}, 0);
            @(posedge clk); #1;
            if (ref_err < 255) ref_err++;
            check("err_count", bus.err_count, ref_err);
        end else begin
            cyc = 0; n_stall = 0; n_re = 0; done = 0;
            exp_cyc = (nbytes == 4) ? 2 : 4;
            while (!done && cyc < 10) begin
                @(negedge clk);
                cyc++;
                if (bus.stall)  n_stall++;
                if (bus.mem_re) n_re++;
                if (cyc == 1) check("accept_no_err", bus.align_err, 0);
                if (bus.mem_we) begin
                    check("wr_addr", bus.mem_addr, wa);
                    check("wr_data", bus.mem_wdata, exp_w);
                    check("wr_stall", bus.stall, 0);
                    done = 1;
                end
                @(posedge clk); #1;
            end
            check("write_seen", done, 1);
            check("latency", cyc, exp_cyc);
            check("stall_cycles", n_stall, exp_cyc - 1);
            check("read_count", n_re, (nbytes == 4) ? 0 : 1);
            ref_mem[wa] = exp_w;
        end
        bus.st_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.st_valid = 1'b0; bus.st_half = 1'b0; bus.st_byte = 1'b0;
        bus.st_addr  = '0;   bus.st_data = '0;
        @(posedge clk); #1;
        for (int i = 0; i < DEPTH; i++) preload(i, $urandom);

        check("rst_stall", bus.stall, 0);
        check("rst_re", bus.mem_re, 0);
        check("rst_we", bus.mem_we, 0);
        check("rst_align_err", bus.align_err, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_err_count", bus.err_count, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // directed cases
        do_store(0, 32'h08, 32'hDEAD_BEEF);
        check("sw_mem2", ref_mem[2], 32'hDEAD_BEEF);
        preload(1, 32'h1122_3344);
        do_store(2, 32'h06, 32'h0000_00AB);
        check("sb_mem1", ref_mem[1], 32'h11AB_3344);
        preload(0, 32'h1122_3344);
        do_store(1, 32'h02, 32'h1234_CAFE);
        check("sh_mem0", ref_mem[0], 32'hCAFE_3344);
        preload(0, 32'h1122_3344);
        do_store(3, 32'h02, 32'h1234_CAFE);
        do_store(1, 32'h03, 32'h5555_5555);
        do_store(0, 32'h05, 32'h6666_6666);
        check("err_two", bus.err_count, 2);
        do_store(2, 32'h00, 32'hA5A5_A5A5);
        do_store(0, 32'h04, 32'h0BAD_F00D);

        // saturation
        for (int i = 0; i < 300; i++) do_store((i % 2 == 0) ? 1 : 0, 32'h03, 32'h0);
        check("err_saturated", bus.err_count, 255);

        // reset during MERGE of an sb @0x04
        bus.st_valid = 1'b1; bus.st_byte = 1'b1; bus.st_half = 1'b0;
        bus.st_addr  = 32'h04; bus.st_data = 32'h0000_0077;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_kill_stall", bus.stall, 1);
        reset = 1'b1;
        #1;
        check("kill_stall", bus.stall, 0);
        check("kill_strobes", {bus.mem_re, bus.mem_we}, 0);
        check("kill_mem_addr", bus.mem_addr, 0);
        check("kill_mem_wdata", bus.mem_wdata, 0);
        check("kill_err_count", bus.err_count, 0);
        bus.st_valid = 1'b0;
        ref_err = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        do_store(0, 32'h10, 32'hC0FF_EE00);

        // randomized traffic, mostly back-to-back
        for (int i = 0; i < 250; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b10;
            do_store(int'($urandom_range(0, 3)), a, $urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end

        @(posedge clk); #1;
        for (int i = 0; i < DEPTH; i++) check("final_mem", dmem[i], ref_mem[i]);
        check("re_we_never_both", both_strobes, 0);
        check("no_we_in_reset", we_in_reset, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
